egg_round_ctrl: RTL and testbench

EGG_ROUND_CTRL -- requirements
Module: egg_round_ctrl

---
 rtl/egg_round_ctrl.sv | 140 ++++++++++++++
 tb/tb_egg_round_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/egg_round_ctrl.sv
// egg_round_ctrl: whack-an-egg round sequencer with a ms tick prescaler, scoring and lives.
// Define ROUND_SPEEDUP_EN to shrink the display window as the score rises.
module egg_round_ctrl #(
  parameter int TICK_DIV   = 50000,
  parameter int SHOW_MS    = 1000,
  parameter int GAP_MS     = 300,
  parameter int SHOW_MIN   = 250,
  parameter int SPEED_STEP = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] hit_key,
  input  logic [16:0] rnd_pos,
  input  logic [1:0]  rnd_color,
  output logic        remake,
  output logic [15:0] egg_pos,
  output logic [1:0]  egg_color,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        hit_flag
);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SPAWN = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] SHOW  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [2:0] OVER  = 3'd5;

  logic [2:0]    state, state_next;
  logic [DW-1:0] div_cnt;
  logic [15:0]   cnt;
  logic [15:0]   window;
  logic [15:0]   cand;
  logic          tick, pos_valid, hit, bomb, expire, lose;
  logic [1:0]    lives_dec;
  logic [8:0]    sum;
  logic [7:0]    score_sat;

`ifdef ROUND_SPEEDUP_EN
  int reduce;
  always_comb begin
    reduce = int'(score[7:3]) * SPEED_STEP;
    // Compare before subtracting so the window never wraps below SHOW_MIN.
    if (reduce >= SHOW_MS - SHOW_MIN)
      window = 16'(SHOW_MIN);
    else
      window = 16'(SHOW_MS - reduce);
  end
`else
  assign window = 16'(SHOW_MS);
`endif

  assign tick      = (div_cnt == DIV_LAST);
  assign cand      = rnd_pos[16:1];
  assign pos_valid = !rnd_pos[0] && (cand != 16'd0) && ((cand & (cand - 16'd1)) == 16'd0)
                     && (rnd_color != 2'b00);
  assign hit       = |(hit_key & egg_pos);
  assign bomb      = (egg_color == 2'b11);
  assign expire    = tick && (cnt <= 16'd1);
  // A hit outranks a simultaneous expiry.
  assign lose      = hit ? bomb : (expire && !bomb);
  assign lives_dec = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
  assign sum       = {1'b0, score} + ((egg_color == 2'b10) ? 9'd2 : 9'd1);
  assign score_sat = sum[8] ? 8'hFF : sum[7:0];

  assign remake    = (state == SPAWN);
  assign game_over = (state == OVER);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, OVER: if (start) state_next = SPAWN;
      SPAWN:      state_next = WAIT;
      WAIT:       state_next = pos_valid ? SHOW : SPAWN;
      SHOW:       if (hit || expire) state_next = (lose && lives_dec == 2'd0) ? OVER : GAP;
      GAP:        if (tick && cnt <= 16'd1) state_next = SPAWN;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      cnt       <= '0;
      egg_pos   <= '0;
      egg_color <= '0;
      score     <= '0;
      lives     <= '0;
      hit_flag  <= 1'b0;
    end else begin
      state    <= state_next;
      hit_flag <= 1'b0;
      // Prescaler phase is realigned whenever a timed state begins.
      if ((state_next == SHOW || state_next == GAP) && state_next != state)
        div_cnt <= '0;
      else if (tick)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 1'b1;

      case (state)
        IDLE, OVER: begin
          if (start) begin
            score <= 8'd0;
            lives <= 2'd3;
          end
        end
        WAIT: begin
          if (pos_valid) begin
            egg_pos   <= cand;
            egg_color <= rnd_color;
            cnt       <= window;
          end
        end
        SHOW: begin
          if (hit || expire) begin
            egg_pos   <= '0;
            egg_color <= '0;
            cnt       <= 16'(GAP_MS);
            if (lose) lives <= lives_dec;
            if (hit && !bomb) begin
              score    <= score_sat;
              hit_flag <= 1'b1;
            end
          end else if (tick) begin
            cnt <= cnt - 16'd1;
          end
        end
        GAP: if (tick) cnt <= cnt - 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_egg_round_ctrl.sv
// Directed self-checking bench for egg_round_ctrl with a small tick/window configuration.
module tb_egg_round_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] hit_key;
  logic [16:0] rnd_pos;
  logic [1:0]  rnd_color;
  logic        remake;
  logic [15:0] egg_pos;
  logic [1:0]  egg_color;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        game_over;
  logic        hit_flag;

  int errors = 0;
  int checks = 0;

  egg_round_ctrl #(.TICK_DIV(2), .SHOW_MS(4), .GAP_MS(2), .SHOW_MIN(2), .SPEED_STEP(1)) dut (
    .clk(clk), .rst(rst), .start(start), .hit_key(hit_key), .rnd_pos(rnd_pos),
    .rnd_color(rnd_color), .remake(remake), .egg_pos(egg_pos), .egg_color(egg_color),
    .score(score), .lives(lives), .game_over(game_over), .hit_flag(hit_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; hit_key = '0; rnd_pos = '0; rnd_color = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic begin_game();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // From SPAWN: present an egg, pass through WAIT, land in the first SHOW cycle.
  task automatic load_egg(input logic [16:0] pos, input logic [1:0] col);
    rnd_pos = pos; rnd_color = col;
    step();
    step();
  endtask

  task automatic gap_wait();
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hit_key = '0; rnd_pos = 17'h00008; rnd_color = 2'b01;
    repeat (2) step();
    checks++; if ({remake, egg_pos, egg_color, score, lives, game_over, hit_flag} !== 30'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0",
        {remake, egg_pos, egg_color, score, lives, game_over, hit_flag}); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (remake !== 1'b0) begin
        errors++; $display("FAIL idle_no_start_%0d: remake got %b expected 0", i, remake); end
    end
  endtask

  task automatic test_hit();
    do_reset();
    begin_game();
    checks++; if (remake !== 1'b1 || score !== 8'd0 || lives !== 2'd3) begin
      errors++; $display("FAIL start_load: remake=%b score=%0d lives=%0d expected 1/0/3", remake, score, lives); end
    rnd_pos = 17'h00008; rnd_color = 2'b01;
    step();
    checks++; if (remake !== 1'b0) begin
      errors++; $display("FAIL remake_one_cycle: got %b expected 0", remake); end
    step();
    checks++; if (egg_pos !== 16'h0004 || egg_color !== 2'b01) begin
      errors++; $display("FAIL show_load: pos=%h col=%b expected 0004/01", egg_pos, egg_color); end
    hit_key = 16'h0004;
    step();
    hit_key = '0;
    checks++; if (score !== 8'd1 || hit_flag !== 1'b1 || lives !== 2'd3 || egg_pos !== 16'h0) begin
      errors++; $display("FAIL hit_score: score=%0d flag=%b lives=%0d pos=%h expected 1/1/3/0000",
        score, hit_flag, lives, egg_pos); end
    step();
    checks++; if (hit_flag !== 1'b0) begin
      errors++; $display("FAIL hit_flag_pulse: got %b expected 0", hit_flag); end
    repeat (2) step();
    checks++; if (remake !== 1'b0) begin
      errors++; $display("FAIL gap_length: remake got %b expected 0 at gap end", remake); end
    step();
    checks++; if (remake !== 1'b1) begin
      errors++; $display("FAIL gap_to_spawn: remake got %b expected 1", remake); end
  endtask

  task automatic test_expiry();
    do_reset();
    begin_game();
    load_egg(17'h00010, 2'b10);
    repeat (7) step();
    checks++; if (egg_pos !== 16'h0008) begin
      errors++; $display("FAIL window_hold: pos got %h expected 0008", egg_pos); end
    step();
    checks++; if (egg_pos !== 16'h0 || lives !== 2'd2 || score !== 8'd0) begin
      errors++; $display("FAIL expire_miss: pos=%h lives=%0d score=%0d expected 0000/2/0", egg_pos, lives, score); end
    gap_wait();
    load_egg(17'h00002, 2'b11);
    repeat (8) step();
    checks++; if (egg_pos !== 16'h0 || lives !== 2'd2) begin
      errors++; $display("FAIL bomb_expire: pos=%h lives=%0d expected 0000/2", egg_pos, lives); end
  endtask

  task automatic test_invalid_and_keys();
    do_reset();
    begin_game();
    load_egg(17'h1AAAA, 2'b01);
    checks++; if (remake !== 1'b1 || egg_pos !== 16'h0) begin
      errors++; $display("FAIL respawn_multi: remake=%b pos=%h expected 1/0000", remake, egg_pos); end
    load_egg(17'h00001, 2'b01);
    checks++; if (remake !== 1'b1) begin
      errors++; $display("FAIL respawn_bit0: remake got %b expected 1", remake); end
    load_egg(17'h00020, 2'b00);
    checks++; if (remake !== 1'b1) begin
      errors++; $display("FAIL respawn_color0: remake got %b expected 1", remake); end
    load_egg(17'h00020, 2'b10);
    checks++; if (egg_pos !== 16'h0010 || egg_color !== 2'b10) begin
      errors++; $display("FAIL valid_after_retry: pos=%h col=%b expected 0010/10", egg_pos, egg_color); end
    hit_key = 16'h0001;
    step();
    checks++; if (egg_pos !== 16'h0010 || score !== 8'd0) begin
      errors++; $display("FAIL wrong_key: pos=%h score=%0d expected 0010/0", egg_pos, score); end
    hit_key = 16'h8011;
    step();
    hit_key = '0;
    checks++; if (score !== 8'd2 || hit_flag !== 1'b1) begin
      errors++; $display("FAIL multi_key_hit: score=%0d flag=%b expected 2/1", score, hit_flag); end
    gap_wait();
    load_egg(17'h00040, 2'b11);
    hit_key = 16'h0020;
    step();
    hit_key = '0;
    checks++; if (lives !== 2'd2 || score !== 8'd2 || hit_flag !== 1'b0 || egg_pos !== 16'h0) begin
      errors++; $display("FAIL bomb_hit: lives=%0d score=%0d flag=%b pos=%h expected 2/2/0/0000",
        lives, score, hit_flag, egg_pos); end
  endtask

  task automatic test_game_over();
    do_reset();
    begin_game();
    for (int r = 0; r < 3; r++) begin
      load_egg(17'h00004, 2'b01);
      repeat (8) step();
      checks++; if (lives !== 2'(2 - r)) begin
        errors++; $display("FAIL lives_count_%0d: got %0d expected %0d", r, lives, 2 - r); end
      if (r < 2) gap_wait();
    end
    checks++; if (game_over !== 1'b1 || egg_pos !== 16'h0) begin
      errors++; $display("FAIL enter_over: game_over=%b pos=%h expected 1/0000", game_over, egg_pos); end
    hit_key = 16'hFFFF;
    repeat (2) step();
    hit_key = '0;
    checks++; if (score !== 8'd0 || hit_flag !== 1'b0 || game_over !== 1'b1 || lives !== 2'd0 || remake !== 1'b0) begin
      errors++; $display("FAIL over_hold: score=%0d flag=%b over=%b lives=%0d remake=%b expected 0/0/1/0/0",
        score, hit_flag, game_over, lives, remake); end
    begin_game();
    checks++; if (score !== 8'd0 || lives !== 2'd3 || game_over !== 1'b0 || remake !== 1'b1) begin
      errors++; $display("FAIL restart: score=%0d lives=%0d over=%b remake=%b expected 0/3/0/1",
        score, lives, game_over, remake); end
  endtask

  task automatic test_last_tick_and_reset();
    do_reset();
    begin_game();
    load_egg(17'h00008, 2'b01);
    repeat (7) step();
    hit_key = 16'h0004;
    step();
    hit_key = '0;
    checks++; if (score !== 8'd1 || hit_flag !== 1'b1 || lives !== 2'd3) begin
      errors++; $display("FAIL last_tick_hit: score=%0d flag=%b lives=%0d expected 1/1/3", score, hit_flag, lives); end
    gap_wait();
    load_egg(17'h00008, 2'b10);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (egg_pos !== 16'h0004 || lives !== 2'd3 || score !== 8'd1) begin
      errors++; $display("FAIL start_ignored: pos=%h lives=%0d score=%0d expected 0004/3/1", egg_pos, lives, score); end
    rst = 1'b1;
    #1;
    checks++; if ({remake, egg_pos, egg_color, score, lives, game_over, hit_flag} !== 30'd0) begin
      errors++; $display("FAIL async_reset: got %h expected 0",
        {remake, egg_pos, egg_color, score, lives, game_over, hit_flag}); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    begin_game();
    for (int n = 1; n <= 129; n++) begin
      load_egg(17'h00008, 2'b10);
      hit_key = 16'h0004;
      step();
      hit_key = '0;
      if (n >= 127) begin
        checks++; if (score !== ((n == 127) ? 8'd254 : 8'd255)) begin
          errors++; $display("FAIL saturate_%0d: score got %0d expected %0d", n, score, (n == 127) ? 254 : 255); end
      end
      gap_wait();
    end
    checks++; if (lives !== 2'd3) begin
      errors++; $display("FAIL saturate_lives: got %0d expected 3", lives); end
  endtask

`ifdef ROUND_SPEEDUP_EN
  task automatic test_speedup();
    do_reset();
    begin_game();
    for (int n = 0; n < 8; n++) begin
      load_egg(17'h00008, 2'b10);
      hit_key = 16'h0004;
      step();
      hit_key = '0;
      gap_wait();
    end
    load_egg(17'h00008, 2'b01);
    repeat (3) step();
    checks++; if (egg_pos !== 16'h0004) begin
      errors++; $display("FAIL speedup_hold: pos got %h expected 0004", egg_pos); end
    step();
    checks++; if (egg_pos !== 16'h0 || lives !== 2'd2 || score !== 8'd16) begin
      errors++; $display("FAIL speedup_window: pos=%h lives=%0d score=%0d expected 0000/2/16", egg_pos, lives, score); end
  endtask
`endif

  initial begin
    test_reset();
    test_hit();
    test_expiry();
    test_invalid_and_keys();
    test_game_over();
    test_last_tick_and_reset();
    test_saturation();
`ifdef ROUND_SPEEDUP_EN
    test_speedup();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
